// File: rtl/dmem_responder.sv
// Data-memory responder for the core's memory stage: word RAM, byte-lane stores, aligned/extended loads.
// Latency: response LATENCY edges after accept for aligned requests; error requests respond on the accept edge.
// Backpressure: stall holds the pipeline from the request cycle through BUSY; drops in RESP.
// Ports: clk/rst (async active-high); req_valid/req_we/req_funct3/req_addr/req_wdata from the memory stage;
//        stall to the pipeline; resp_valid one-cycle pulse qualifying resp_rdata and err.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q;
    logic [2:0]         f3_q;
    logic [ADDR_W+1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [31:0]        mem [2**ADDR_W];

    logic               req_bad;
    logic               finish;
    logic [ADDR_W-1:0]  word_idx;
    logic [1:0]         lane;
    logic [31:0]        word_rd;
    logic [31:0]        shifted;
    logic [31:0]        load_fmt;
    logic [3:0]         be;
    logic [31:0]        st_dat;

    // Address bits above the RAM index wrap around and are deliberately ignored.
    logic               unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    // Illegal funct3, store with an unsigned-load encoding, or misaligned half/word.
    always_comb begin
        req_bad = 1'b0;
        case (req_funct3)
            3'b000:          req_bad = 1'b0;
            3'b001:          req_bad = req_addr[0];
            3'b010:          req_bad = (req_addr[1:0] != 2'b00);
            3'b100:          req_bad = req_we;
            3'b101:          req_bad = req_we | req_addr[0];
            default:         req_bad = 1'b1;
        endcase
    end

    assign word_idx = addr_q[ADDR_W+1:2];
    assign lane     = addr_q[1:0];
    assign finish   = (state_q == BUSY) && (cnt_q == 4'd0);

    // Load path: shift the addressed lane down, then extend per funct3.
    assign word_rd = mem[word_idx];
    assign shifted = word_rd >> {lane, 3'b000};

    always_comb begin
        load_fmt = word_rd;
        case (f3_q)
            3'b000:  load_fmt = {{24{shifted[7]}},  shifted[7:0]};
            3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_fmt = {24'd0, shifted[7:0]};
            3'b101:  load_fmt = {16'd0, shifted[15:0]};
            default: load_fmt = word_rd;
        endcase
    end

    // Store path: replicate the low byte/half across lanes and let be pick the target.
    always_comb begin
        be     = 4'b1111;
        st_dat = wdata_q;
        case (f3_q)
            3'b000: begin
                be     = 4'b0001 << lane;
                st_dat = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                be     = lane[1] ? 4'b1100 : 4'b0011;
                st_dat = {2{wdata_q[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                st_dat = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        state_d = RESP;
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'd0 : load_fmt;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr[ADDR_W+1:0];
                wdata_q <= req_wdata;
            end
        end
    end

    // RAM is not reset; a reset forces state_q to IDLE so finish is low and a pending store is dropped.
    always_ff @(posedge clk) begin
        if (finish && we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= st_dat[8*i +: 8];
            end
        end
    end

    assign stall      = ((state_q == IDLE) && req_valid) || (state_q == BUSY);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stores/loads with byte lanes, errors, back-to-back, wrap, reset mid-store.
// Latency: checks LATENCY=2 response timing and zero extra edges for error requests.
// Backpressure: checks stall in request, BUSY and RESP cycles.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;
    int n_resp = 0;

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (resp_valid) n_resp++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One request; returns once resp_valid is seen, then steps past the RESP cycle.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input string tag,
                        output logic [31:0] rd, output logic e, output int lat);
        bit busy_ok;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        #1 chk({tag, "_stall_req"}, stall, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!resp_valid && lat < 40) begin
            if (!stall) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_stall_busy"}, busy_ok, 1);
        chk({tag, "_stall_resp"}, stall, 0);
        rd = resp_rdata;
        e  = err;
        @(posedge clk); #1;
        chk({tag, "_one_pulse"}, resp_valid, 0);
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input string tag);
        logic [31:0] rd; logic e; int lat;
        xact(1'b1, f3, a, wd, tag, rd, e, lat);
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_err"}, e, 0);
        chk({tag, "_rd"}, rd, 0);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] rd; logic e; int lat;
        xact(1'b0, f3, a, 32'h0, tag, rd, e, lat);
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_err"}, e, 0);
        chk({tag, "_rd"}, rd, exp);
    endtask

    task automatic bad(input logic we, input logic [2:0] f3, input logic [31:0] a, input string tag);
        logic [31:0] rd; logic e; int lat;
        xact(we, f3, a, 32'hCAFEF00D, tag, rd, e, lat);
        chk({tag, "_lat"}, lat, 0);
        chk({tag, "_err"}, e, 1);
        chk({tag, "_rd"}, rd, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int nr0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_rv", resp_valid, 0);
        chk("rst_rd", resp_rdata, 0);
        chk("rst_err", err, 0);
        @(negedge clk) rst = 1'b0;

        // Word store and readback
        st(3'b010, 32'h10, 32'hDEADBEEF, "sw10");
        ld(3'b010, 32'h10, 32'hDEADBEEF, "lw10");

        // Byte lanes
        st(3'b000, 32'h13, 32'h00000080, "sb13");
        ld(3'b010, 32'h10, 32'h80ADBEEF, "lw10_sb");
        ld(3'b000, 32'h13, 32'hFFFFFF80, "lb13");
        ld(3'b100, 32'h13, 32'h00000080, "lbu13");
        st(3'b001, 32'h10, 32'hFFFF1234, "sh10");
        ld(3'b010, 32'h10, 32'h80AD1234, "lw10_sh");
        ld(3'b001, 32'h12, 32'hFFFF80AD, "lh12");
        ld(3'b101, 32'h12, 32'h000080AD, "lhu12");
        ld(3'b000, 32'h10, 32'h00000034, "lb10");

        // Errors
        bad(1'b0, 3'b010, 32'h12, "lw12_mis");
        bad(1'b1, 3'b001, 32'h11, "sh11_mis");
        ld(3'b010, 32'h10, 32'h80AD1234, "lw10_after_err");
        bad(1'b0, 3'b011, 32'h10, "ld_f3_011");
        bad(1'b1, 3'b100, 32'h10, "st_f3_100");

        // Back-to-back with req_valid held across RESP
        st(3'b010, 32'h30, 32'h00000000, "sw30_clr");
        nr0 = n_resp;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h30; req_wdata = 32'h0BADF00D;
        @(posedge clk); #1;
        lat = 0;
        while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("b2b_lat1", lat, 2);
        req_we = 1'b0;
        @(posedge clk); #1;
        chk("b2b_idle_rv", resp_valid, 0);
        chk("b2b_idle_stall", stall, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("b2b_lat2", lat, 2);
        chk("b2b_rd", resp_rdata, 32'h0BADF00D);
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_count", n_resp - nr0, 2);
        chk("b2b_idle_after", stall, 0);

        // Wrap-around of address bits above the RAM index
        st(3'b010, 32'h00001004, 32'h5A5A5A5A, "sw_wrap");
        ld(3'b010, 32'h00000004, 32'h5A5A5A5A, "lw_wrap");

        // Reset in the middle of a store
        st(3'b010, 32'h20, 32'h11111111, "sw20");
        ld(3'b010, 32'h20, 32'h11111111, "lw20_pre");
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_busy_stall", stall, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_rv", resp_valid, 0);
        chk("mid_rst_rd", resp_rdata, 0);
        chk("mid_rst_err", err, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        ld(3'b010, 32'h20, 32'h11111111, "lw20_post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
